// File: rtl/led_pkg.sv
// led_pkg: definitions shared by the LED counter and the LED sequence checker.
//   LED_WIDTH       - default LED bus width (also used by the LED counter)
//   led_chk_state_t - sequence checker FSM state encoding (IDLE=0 .. SLIP=3)
package led_pkg;

  localparam int LED_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    SLIP    = 2'd3
  } led_chk_state_t;

endpackage

// File: rtl/led_seq_checker_if.sv
// led_seq_checker_if: control, LED sample and status bundle of the LED sequence checker.
//   master : drives enable, clear_err, leds_in; observes the status outputs
//   slave  : the checker; samples the inputs and drives locked, err_pulse,
//            err_count, last_good and state
interface led_seq_checker_if
  import led_pkg::*;
#(
  parameter int WIDTH     = LED_WIDTH,
  parameter int ERR_CNT_W = 16
) ();

  logic                 enable;
  logic                 clear_err;
  logic [WIDTH-1:0]     leds_in;
  logic                 locked;
  logic                 err_pulse;
  logic [ERR_CNT_W-1:0] err_count;
  logic [WIDTH-1:0]     last_good;
  led_chk_state_t       state;

  modport master (
    output enable, clear_err, leds_in,
    input  locked, err_pulse, err_count, last_good, state
  );

  modport slave (
    input  enable, clear_err, leds_in,
    output locked, err_pulse, err_count, last_good, state
  );

endinterface

// File: rtl/led_sat_counter.sv
// led_sat_counter: W-bit up counter that sticks at all-ones.
//   clk   - clock
//   rst   - asynchronous active-high reset (count -> 0)
//   clr   - synchronous clear; an increment on the same edge leaves count = 1
//   inc   - increment request
//   count - registered count value
module led_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_r;

  // Count register: clear first, then apply the increment, holding at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (clr) begin
      count_r <= inc ? W'(1'b1) : {W{1'b0}};
    end else if (inc && (count_r != {W{1'b1}})) begin
      count_r <= count_r + W'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/led_seq_checker.sv
// led_seq_checker: checks that the LED count stream advances by +1 (mod 2^WIDTH)
// on every enabled led_clk edge, locks after LOCK_COUNT good steps, then flags
// and counts every break in the sequence.
//   led_clk - clock
//   rst     - asynchronous active-high reset
//   bus     - slave side of led_seq_checker_if:
//             enable, clear_err, leds_in in; locked, err_pulse, err_count,
//             last_good, state out (all registered)
module led_seq_checker
  import led_pkg::*;
#(
  parameter int WIDTH      = LED_WIDTH,
  parameter int LOCK_COUNT = 4,
  parameter int MAX_MISS   = 2,
  parameter int ERR_CNT_W  = 16
) (
  input logic               led_clk,
  input logic               rst,
  led_seq_checker_if.slave  bus
);

  localparam int MC_W = $clog2(LOCK_COUNT + 1);
  localparam int MM_W = $clog2(MAX_MISS + 1);
  // Counter values at which the next matching / mismatching edge completes the run.
  localparam logic [MC_W-1:0] LOCK_LAST = MC_W'(LOCK_COUNT - 1);
  localparam logic [MM_W-1:0] MISS_LAST = MM_W'(MAX_MISS - 1);

  led_chk_state_t       state_r;
  logic [WIDTH-1:0]     prev_r;
  logic                 prev_valid_r;
  logic [MC_W-1:0]      match_cnt_r;
  logic [MM_W-1:0]      miss_cnt_r;
  logic                 locked_r;
  logic                 err_pulse_r;
  logic [WIDTH-1:0]     last_good_r;
  logic [WIDTH-1:0]     prev_inc_s;
  logic                 match_s;
  logic                 err_inc_s;
  logic [ERR_CNT_W-1:0] err_count_s;

  // Match decision: the +1 wraps within WIDTH bits, so max -> 0 is a match.
  always_comb begin
    prev_inc_s = prev_r + WIDTH'(1'b1);
    match_s    = prev_valid_r && (bus.leds_in == prev_inc_s);
    err_inc_s  = 1'b0;
    if (bus.enable && !match_s && ((state_r == LOCKED) || (state_r == SLIP))) begin
      err_inc_s = 1'b1;
    end else begin
      err_inc_s = 1'b0;
    end
  end

  // Checker FSM with its registered status outputs.
  always_ff @(posedge led_clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      prev_r       <= {WIDTH{1'b0}};
      prev_valid_r <= 1'b0;
      match_cnt_r  <= {MC_W{1'b0}};
      miss_cnt_r   <= {MM_W{1'b0}};
      locked_r     <= 1'b0;
      err_pulse_r  <= 1'b0;
      last_good_r  <= {WIDTH{1'b0}};
    end else if (!bus.enable) begin
      // Disabled: drop back to IDLE; prev and last_good are held.
      state_r      <= IDLE;
      prev_valid_r <= 1'b0;
      match_cnt_r  <= {MC_W{1'b0}};
      miss_cnt_r   <= {MM_W{1'b0}};
      locked_r     <= 1'b0;
      err_pulse_r  <= 1'b0;
    end else begin
      prev_r       <= bus.leds_in;
      prev_valid_r <= 1'b1;
      err_pulse_r  <= 1'b0;
      case (state_r)
        IDLE: begin
          // This edge only primes prev.
          state_r     <= ACQUIRE;
          match_cnt_r <= {MC_W{1'b0}};
          miss_cnt_r  <= {MM_W{1'b0}};
          locked_r    <= 1'b0;
        end
        ACQUIRE: begin
          if (match_s) begin
            match_cnt_r <= match_cnt_r + MC_W'(1'b1);
            if (match_cnt_r == LOCK_LAST) begin
              state_r  <= LOCKED;
              locked_r <= 1'b1;
            end else begin
              state_r <= ACQUIRE;
            end
          end else begin
            match_cnt_r <= {MC_W{1'b0}};
          end
        end
        LOCKED: begin
          if (match_s) begin
            last_good_r <= bus.leds_in;
          end else begin
            err_pulse_r <= 1'b1;
            if (MAX_MISS == 1) begin
              state_r     <= ACQUIRE;
              match_cnt_r <= {MC_W{1'b0}};
              miss_cnt_r  <= {MM_W{1'b0}};
              locked_r    <= 1'b0;
            end else begin
              state_r    <= SLIP;
              miss_cnt_r <= MM_W'(1'b1);
            end
          end
        end
        SLIP: begin
          if (match_s) begin
            // Resync onto whatever sequence is now running.
            state_r     <= LOCKED;
            miss_cnt_r  <= {MM_W{1'b0}};
            last_good_r <= bus.leds_in;
          end else begin
            err_pulse_r <= 1'b1;
            if (miss_cnt_r >= MISS_LAST) begin
              state_r     <= ACQUIRE;
              match_cnt_r <= {MC_W{1'b0}};
              miss_cnt_r  <= {MM_W{1'b0}};
              locked_r    <= 1'b0;
            end else begin
              miss_cnt_r <= miss_cnt_r + MM_W'(1'b1);
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          match_cnt_r <= {MC_W{1'b0}};
          miss_cnt_r  <= {MM_W{1'b0}};
          locked_r    <= 1'b0;
        end
      endcase
    end
  end

  led_sat_counter #(
    .W (ERR_CNT_W)
  ) u_err_cnt (
    .clk   (led_clk),
    .rst   (rst),
    .clr   (bus.clear_err),
    .inc   (err_inc_s),
    .count (err_count_s)
  );

  assign bus.state     = state_r;
  assign bus.locked    = locked_r;
  assign bus.err_pulse = err_pulse_r;
  assign bus.last_good = last_good_r;
  assign bus.err_count = err_count_s;

endmodule

// File: tb/tb_led_seq_checker.sv
// tb_led_seq_checker: directed self-checking bench for led_seq_checker.
// A second instance with a 2-bit error counter shares the stimulus and is
// used for the saturation checks.
module tb_led_seq_checker;
  import led_pkg::*;

  logic led_clk;
  logic rst;
  int   checks;
  int   failures;

  led_seq_checker_if #(.WIDTH(8), .ERR_CNT_W(16)) bus ();
  led_seq_checker_if #(.WIDTH(8), .ERR_CNT_W(2))  bus2 ();

  led_seq_checker #(
    .WIDTH(8), .LOCK_COUNT(4), .MAX_MISS(2), .ERR_CNT_W(16)
  ) dut (
    .led_clk (led_clk),
    .rst     (rst),
    .bus     (bus)
  );

  led_seq_checker #(
    .WIDTH(8), .LOCK_COUNT(4), .MAX_MISS(2), .ERR_CNT_W(2)
  ) dut_sat (
    .led_clk (led_clk),
    .rst     (rst),
    .bus     (bus2)
  );

  assign bus2.enable    = bus.enable;
  assign bus2.clear_err = bus.clear_err;
  assign bus2.leds_in   = bus.leds_in;

  initial led_clk = 1'b0;
  always #5 led_clk = ~led_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Present one sample, clock it in, and settle 1 ns after the edge.
  task automatic step(input logic [7:0] v);
    bus.leds_in = v;
    @(posedge led_clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.enable    = 1'b0;
    bus.clear_err = 1'b0;
    bus.leds_in   = 8'h00;
    #12;
    check_val("rst_state",     32'(bus.state),     32'(IDLE));
    check_val("rst_locked",    32'(bus.locked),    32'd0);
    check_val("rst_pulse",     32'(bus.err_pulse), 32'd0);
    check_val("rst_errcnt",    32'(bus.err_count), 32'd0);
    check_val("rst_lastgood",  32'(bus.last_good), 32'd0);

    @(negedge led_clk);
    rst        = 1'b0;
    bus.enable = 1'b1;

    // Acquire: 0 primes, 1..4 are the four matching steps.
    step(8'h00);
    check_val("prime_state",   32'(bus.state),  32'(ACQUIRE));
    check_val("prime_locked",  32'(bus.locked), 32'd0);
    for (int v = 1; v <= 3; v++) step(8'(v));
    check_val("acq3_locked",   32'(bus.locked), 32'd0);
    step(8'h04);
    check_val("lock_locked",   32'(bus.locked),    32'd1);
    check_val("lock_state",    32'(bus.state),     32'(LOCKED));
    check_val("lock_errcnt",   32'(bus.err_count), 32'd0);
    step(8'h05);
    check_val("lastgood_5",    32'(bus.last_good), 32'h05);

    // Wrap through 0xFF -> 0x00 without error.
    for (int v = 6; v <= 8'hFD; v++) step(8'(v));
    step(8'hFE); check_val("wrap_fe_pulse", 32'(bus.err_pulse), 32'd0);
    step(8'hFF); check_val("wrap_ff_pulse", 32'(bus.err_pulse), 32'd0);
    step(8'h00); check_val("wrap_00_pulse", 32'(bus.err_pulse), 32'd0);
    step(8'h01); check_val("wrap_01_pulse", 32'(bus.err_pulse), 32'd0);
    check_val("wrap_lastgood", 32'(bus.last_good), 32'h01);
    check_val("wrap_errcnt",   32'(bus.err_count), 32'd0);

    // Single jump: one error, SLIP, then resync on the new sequence.
    for (int v = 2; v <= 8'h0F; v++) step(8'(v));
    step(8'h10);
    step(8'h11); check_val("jump_pre_pulse", 32'(bus.err_pulse), 32'd0);
    step(8'h55);
    check_val("jump_pulse",    32'(bus.err_pulse), 32'd1);
    check_val("jump_state",    32'(bus.state),     32'(SLIP));
    check_val("jump_locked",   32'(bus.locked),    32'd1);
    check_val("jump_errcnt",   32'(bus.err_count), 32'd1);
    step(8'h56);
    check_val("resync_pulse",  32'(bus.err_pulse), 32'd0);
    check_val("resync_state",  32'(bus.state),     32'(LOCKED));
    check_val("resync_errcnt", 32'(bus.err_count), 32'd1);
    check_val("resync_lastgd", 32'(bus.last_good), 32'h56);
    check_val("resync_locked", 32'(bus.locked),    32'd1);

    // Clear on a clean edge, then two misses drop back to ACQUIRE.
    bus.clear_err = 1'b1;
    step(8'h57);
    bus.clear_err = 1'b0;
    check_val("clr_errcnt",    32'(bus.err_count), 32'd0);
    step(8'h20);
    check_val("miss1_pulse",   32'(bus.err_pulse), 32'd1);
    check_val("miss1_state",   32'(bus.state),     32'(SLIP));
    step(8'h40);
    check_val("miss2_pulse",   32'(bus.err_pulse), 32'd1);
    check_val("miss2_state",   32'(bus.state),     32'(ACQUIRE));
    check_val("miss2_locked",  32'(bus.locked),    32'd0);
    check_val("miss2_errcnt",  32'(bus.err_count), 32'd2);
    step(8'h40);
    check_val("acqhold_pulse", 32'(bus.err_pulse), 32'd0);
    check_val("acqhold_errcnt",32'(bus.err_count), 32'd2);

    // Relock, then clear on the same edge as an error.
    step(8'h41); step(8'h42); step(8'h43);
    check_val("relock_pre",    32'(bus.locked), 32'd0);
    step(8'h44);
    check_val("relock_state",  32'(bus.state),  32'(LOCKED));
    bus.clear_err = 1'b1;
    step(8'h77);
    bus.clear_err = 1'b0;
    check_val("clrerr_errcnt", 32'(bus.err_count),  32'd1);
    check_val("clrerr_pulse",  32'(bus.err_pulse),  32'd1);
    check_val("clrerr_sat",    32'(bus2.err_count), 32'd1);

    // Five errors since the clear: 16-bit counter reaches 5, 2-bit one holds 3.
    step(8'h78); check_val("e1_relock", 32'(bus.state), 32'(LOCKED));
    step(8'h00); check_val("e2_errcnt", 32'(bus.err_count), 32'd2);
    step(8'h01);
    step(8'h50);
    check_val("e3_errcnt",     32'(bus.err_count),  32'd3);
    check_val("e3_sat",        32'(bus2.err_count), 32'd3);
    step(8'h51);
    step(8'h51);
    check_val("hold_pulse",    32'(bus.err_pulse),  32'd1);
    check_val("hold_errcnt",   32'(bus.err_count),  32'd4);
    step(8'h52);
    step(8'h70);
    check_val("e5_errcnt",     32'(bus.err_count),  32'd5);
    check_val("e5_sat",        32'(bus2.err_count), 32'd3);
    step(8'h71);
    check_val("e5_resync",     32'(bus.last_good),  32'h71);

    // Asynchronous reset between edges while LOCKED.
    #2;
    rst = 1'b1;
    #1;
    check_val("arst_locked",   32'(bus.locked),     32'd0);
    check_val("arst_errcnt",   32'(bus.err_count),  32'd0);
    check_val("arst_lastgood", 32'(bus.last_good),  32'd0);
    check_val("arst_state",    32'(bus.state),      32'(IDLE));
    check_val("arst_sat",      32'(bus2.err_count), 32'd0);
    @(negedge led_clk);
    rst = 1'b0;
    step(8'h80);
    check_val("rearm_state",   32'(bus.state),  32'(ACQUIRE));
    step(8'h81); step(8'h82); step(8'h83);
    check_val("rearm_pre",     32'(bus.locked), 32'd0);
    step(8'h84);
    check_val("rearm_locked",  32'(bus.locked), 32'd1);
    step(8'h85);
    check_val("rearm_lastgd",  32'(bus.last_good), 32'h85);

    // Disable with a mismatching sample: IDLE, no pulse, counts held.
    bus.enable = 1'b0;
    step(8'h10);
    check_val("dis_state",     32'(bus.state),     32'(IDLE));
    check_val("dis_locked",    32'(bus.locked),    32'd0);
    check_val("dis_pulse",     32'(bus.err_pulse), 32'd0);
    check_val("dis_errcnt",    32'(bus.err_count), 32'd0);
    check_val("dis_lastgood",  32'(bus.last_good), 32'h85);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_seq_checker.md
# led_seq_checker

Monitors the 8-bit LED count stream produced by the LED blink counter and checks that it advances by exactly +1 (mod 2^WIDTH) on every led_clk cycle. It acquires lock after a run of consecutive correct increments, then flags and counts every sequence break. It sits beside the LED counter in the led_clk domain and serves as the built-in self-check and bring-up monitor for the LED driver chain.

## Interface
- WIDTH, 8, width of the monitored LED bus
- LOCK_COUNT, 4, consecutive correct increments required to enter LOCKED (≥1)
- MAX_MISS, 2, consecutive mismatches in LOCKED/SLIP before falling back to ACQUIRE (≥1)
- ERR_CNT_W, 16, width of the saturating error counter

- led_clk  in  1  clock; reset rst, asynchronous, active-high; clock led_clk
- rst  in  1  asynchronous active-high reset
- enable  in  1  checker active when high
- clear_err  in  1  synchronous clear of err_count
- leds_in  in  WIDTH  LED count value, driven from the led_clk domain
- locked  out  1  high in LOCKED and SLIP
- err_pulse  out  1  one-cycle pulse per detected mismatch
- err_count  out  ERR_CNT_W  saturating mismatch count
- last_good  out  WIDTH  most recent leds_in that matched while in LOCKED/SLIP
- state  out  2  current FSM state encoding

## Operation
- Register prev holds the previous sample; prev_valid marks it usable. match = prev_valid && (leds_in == prev + 1), with the addition truncated to WIDTH bits (0xFF→0x00 is a match).
- prev <= leds_in on every edge with enable=1; prev_valid set on the first enabled edge.
- IDLE (0): entered on reset or when enable=0. Clears prev_valid, match_cnt and miss_cnt; sets locked=0. err_count and last_good are held. Moves to ACQUIRE on the first edge with enable=1, which primes prev.
- ACQUIRE (1): on match, match_cnt++; otherwise match_cnt=0. Mismatches are not counted as errors. When match_cnt reaches LOCK_COUNT, move to LOCKED.
- LOCKED (2): on match, last_good <= leds_in. On mismatch, err_pulse=1, err_count++, miss_cnt=1, move to SLIP. If MAX_MISS=1, move to ACQUIRE instead and clear match_cnt.
- SLIP (3): on match, move to LOCKED, miss_cnt=0, last_good <= leds_in. This resyncs to the new sequence. On mismatch, err_pulse=1, err_count++, miss_cnt++. When miss_cnt reaches MAX_MISS, move to ACQUIRE and clear match_cnt.
- A hold (leds_in == prev) is a mismatch.
- err_count saturates at all-ones.
- clear_err zeroes err_count. If an error occurs on the same edge, err_count becomes 1.
- enable=0 from any state moves to IDLE on that edge and suppresses err_pulse.

## Timing
- All outputs are registered. The decision uses leds_in and prev at edge k, and outputs update after edge k.
- Reset values: locked=0, err_pulse=0, err_count=0, last_good=0, state=IDLE. Internally prev=0, prev_valid=0, match_cnt=0, miss_cnt=0.
- rst takes effect asynchronously mid-operation, with no wait for an edge. Release is synchronous to the first led_clk edge.
- Lock latency from enable: 1 priming edge + LOCK_COUNT matching edges. With defaults, locked rises after the 5th sampled edge.
- err_pulse is high for exactly one cycle per mismatching edge. Back-to-back mismatches give consecutive pulses.

## Structure
- Shared package led_pkg: typedef enum logic [1:0] led_chk_state_t {IDLE, ACQUIRE, LOCKED, SLIP} with encodings 0 to 3, plus the default LED width constant shared with the LED counter.
- One sub-module, led_sat_counter: parameterised width, synchronous clear, increment, and saturation, with clear-then-increment priority. It is used for err_count.

## Test plan
- Reset, enable=1, leds_in = 0,1,2,3,4,5 on successive edges -> locked=1 after the edge sampling 4, state=LOCKED, err_count=0.
- While locked, feed 0xFE,0xFF,0x00,0x01 -> no err_pulse, last_good=0x01.
- While locked, feed 0x10,0x11,0x55,0x56 -> one err_pulse on 0x55, state SLIP, then LOCKED on 0x56, err_count=1, last_good=0x56, locked stays 1.
- While locked, feed 0x20,0x40,0x40 (MAX_MISS=2) -> two err_pulses, err_count=2, state ACQUIRE, locked=0.
- clear_err on the same edge as a mismatch -> err_count=1. With ERR_CNT_W=2, 5 errors -> err_count=3.
- Assert rst between edges while LOCKED -> locked, err_count, last_good and state go to 0 immediately. After release, the first edge primes and re-acquire takes 5 edges.
